pq_stream_adapter: RTL and testbench
====================================

PQ_STREAM_ADAPTER -- requirements
Module: pq_stream_adapter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of queue entries.
REQ-002 SHALL have parameter QUEUE_SIZE, default 4096, capacity of the attached systolic priority queue.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 2, idle cycles the queue needs after any operation before its head is valid (range 1..15).
REQ-004 SHALL have ports: CLK in 1 clock; RSTn in 1 async active-low reset. One clock; reset is asynchronous and active-low.
REQ-005 SHALL have ports: s_valid in 1, s_ready out 1, s_data in DATA_WIDTH (push channel).
REQ-006 SHALL have ports: m_valid out 1, m_ready in 1, m_data out DATA_WIDTH (pop channel, minimum first).
REQ-007 SHALL have ports: q_wrt out 1, q_read out 1, q_data out DATA_WIDTH (queue commands).
REQ-008 SHALL have ports: q_full in 1, q_empty in 1, q_head in DATA_WIDTH (queue status, head value).
REQ-009 SHALL have port o_count out $clog2(QUEUE_SIZE+1), local occupancy count.

Function
REQ-010 SHALL implement FSM states SETTLED and SETTLING, with a down-counter settle_cnt.
REQ-011 In SETTLED: m_valid = !q_empty; m_data = q_head; s_ready = !q_full || (m_valid && m_ready).
REQ-012 In SETTLING: m_valid = 0, s_ready = 0, q_wrt = 0, q_read = 0.
REQ-013 Push fire (s_valid && s_ready) SHALL assert q_wrt and drive q_data = s_data in the same cycle.
REQ-014 Pop fire (m_valid && m_ready) SHALL assert q_read in the same cycle.
REQ-015 Simultaneous push and pop fire SHALL assert q_wrt and q_read together (replace); o_count unchanged.
REQ-016 Any fire SHALL move the FSM to SETTLING with settle_cnt = SETTLE_CYCLES; SETTLING decrements each cycle and returns to SETTLED when the counter reaches 1.
REQ-017 No fire in SETTLED SHALL keep the FSM in SETTLED; throughput is one operation per SETTLE_CYCLES+1 cycles.
REQ-018 o_count SHALL +1 on push-only fire and -1 on pop-only fire, saturating at 0 and QUEUE_SIZE.
REQ-019 Full with push pending and no pop: s_ready = 0 and q_wrt SHALL NOT assert.
REQ-020 Empty: m_valid = 0; a push in the same cycle SHALL NOT produce m_valid before settling completes.
REQ-021 m_data SHALL be stable while m_valid && !m_ready.
REQ-022 q_data SHALL be 0 when q_wrt = 0.

Reset
REQ-023 While RSTn = 0: FSM = SETTLED, settle_cnt = 0, o_count = 0, and s_ready, m_valid, q_wrt and q_read = 0.
REQ-024 Reset asserted mid-SETTLING SHALL abort settling immediately; the queue SHALL share RSTn.
REQ-025 After reset release, the first push SHALL be accepted in the first cycle s_valid is high.

Configuration
REQ-026 Macro PQ_STREAM_ADAPTER_STATS_EN defined: SHALL add outputs o_push_cnt, o_pop_cnt, o_stall_cnt (32-bit, wrap, reset 0); o_stall_cnt increments in each cycle where s_valid && !s_ready.
REQ-027 Macro undefined: these ports and their logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-028 Reset then push 7, 3, 9 (each when s_ready) -> q_wrt pulses spaced 3 cycles apart (SETTLE_CYCLES=2); o_count = 3; m_data = 3 after settling.
REQ-029 Pop three times with m_ready held high -> m_data sequence 3, 7, 9, with m_valid low for 2 cycles between pops; then m_valid = 0 and o_count = 0.
REQ-030 Fill to QUEUE_SIZE=4 with 10, 20, 30, 40; hold s_valid = 1 with s_data = 5 and m_ready = 0 -> s_ready = 0, no q_wrt, and o_stall_cnt increments when STATS_EN is defined.
REQ-031 Full, s_valid = 1 with s_data = 5 and m_ready = 1 -> q_wrt and q_read assert together, o_count stays 4, and the next m_data = 5.
REQ-032 Push 8, assert RSTn = 0 during SETTLING -> all outputs are 0 immediately; after release o_count = 0 and m_valid = 0.

Source files
------------

// File: rtl/pq_stream_adapter.sv
// pq_stream_adapter: valid/ready push and pop streams in front of a systolic priority queue that must settle after each operation.
// Define PQ_STREAM_ADAPTER_STATS_EN to add the push, pop and stall counters.
module pq_stream_adapter #(
    parameter int DATA_WIDTH    = 16,
    parameter int QUEUE_SIZE    = 4096,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                             CLK,
    input  logic                             RSTn,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [DATA_WIDTH-1:0]            s_data,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [DATA_WIDTH-1:0]            m_data,
    output logic                             q_wrt,
    output logic                             q_read,
    output logic [DATA_WIDTH-1:0]            q_data,
    input  logic                             q_full,
    input  logic                             q_empty,
    input  logic [DATA_WIDTH-1:0]            q_head,
`ifdef PQ_STREAM_ADAPTER_STATS_EN
    output logic [$clog2(QUEUE_SIZE+1)-1:0] o_count,
    output logic [31:0]                      o_push_cnt,
    output logic [31:0]                      o_pop_cnt,
    output logic [31:0]                      o_stall_cnt
`else
    output logic [$clog2(QUEUE_SIZE+1)-1:0] o_count
`endif
);
    localparam int CW = $clog2(QUEUE_SIZE+1);
    localparam logic [CW-1:0] MAX_COUNT = CW'(QUEUE_SIZE);
    localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

    typedef enum logic {SETTLED, SETTLING} state_t;

    state_t     state;
    logic [3:0] settle_cnt;
    logic       settled;
    logic       push;
    logic       pop;

    // Gating with RSTn forces every handshake output low while reset is held.
    always_comb begin
        settled = RSTn && (state == SETTLED);
        m_valid = settled && !q_empty;
        m_data  = settled ? q_head : '0;
        pop     = m_valid && m_ready;
        s_ready = settled && (!q_full || pop);
        push    = s_valid && s_ready;
        q_wrt   = push;
        q_read  = pop;
        q_data  = push ? s_data : '0;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state      <= SETTLED;
            settle_cnt <= '0;
            o_count    <= '0;
        end else if (push || pop) begin
            state      <= SETTLING;
            settle_cnt <= SETTLE;
            if (push && !pop && o_count != MAX_COUNT)
                o_count <= o_count + CW'(1);
            else if (pop && !push && o_count != '0)
                o_count <= o_count - CW'(1);
        end else if (state == SETTLING) begin
            state      <= (settle_cnt <= 4'd1) ? SETTLED : SETTLING;
            settle_cnt <= settle_cnt - 4'd1;
        end
    end

`ifdef PQ_STREAM_ADAPTER_STATS_EN
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            o_push_cnt  <= '0;
            o_pop_cnt   <= '0;
            o_stall_cnt <= '0;
        end else begin
            if (push)
                o_push_cnt <= o_push_cnt + 32'd1;
            if (pop)
                o_pop_cnt <= o_pop_cnt + 32'd1;
            if (s_valid && !s_ready)
                o_stall_cnt <= o_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pq_stream_adapter.sv
// tb_pq_stream_adapter: directed checks of the adapter against a behavioural min-queue with capacity 4.
module tb_pq_stream_adapter;
    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] s_data = '0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [15:0] m_data;
    logic        q_wrt;
    logic        q_read;
    logic [15:0] q_data;
    logic        q_full = 1'b0;
    logic        q_empty = 1'b1;
    logic [15:0] q_head = '0;
    logic [2:0]  o_count;
`ifdef PQ_STREAM_ADAPTER_STATS_EN
    logic [31:0] o_push_cnt;
    logic [31:0] o_pop_cnt;
    logic [31:0] o_stall_cnt;
    logic [31:0] stall0;
`endif
    int n_chk = 0;
    int n_err = 0;
    logic [15:0] qm[$];

    always #5 CLK = ~CLK;

    pq_stream_adapter #(.DATA_WIDTH(16), .QUEUE_SIZE(4), .SETTLE_CYCLES(2)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .q_wrt(q_wrt), .q_read(q_read), .q_data(q_data),
        .q_full(q_full), .q_empty(q_empty), .q_head(q_head),
`ifdef PQ_STREAM_ADAPTER_STATS_EN
        .o_push_cnt(o_push_cnt), .o_pop_cnt(o_pop_cnt), .o_stall_cnt(o_stall_cnt),
`endif
        .o_count(o_count)
    );

    // Sorted min-queue; a simultaneous write and read replaces the head.
    always @(posedge CLK or negedge RSTn) begin
        int i;
        if (!RSTn) begin
            qm.delete();
        end else begin
            if (q_read && qm.size() != 0)
                void'(qm.pop_front());
            if (q_wrt) begin
                i = 0;
                while (i < qm.size() && qm[i] <= q_data)
                    i++;
                qm.insert(i, q_data);
            end
        end
        q_head  <= (qm.size() != 0) ? qm[0] : 16'd0;
        q_empty <= (qm.size() == 0);
        q_full  <= (qm.size() >= 4);
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        s_valid = 1'b1;
        s_data  = 16'd7;
        #3;
        chk("rst_s_ready", 32'(s_ready), 0);
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_q_wrt", 32'(q_wrt), 0);
        chk("rst_q_read", 32'(q_read), 0);
        chk("rst_count", 32'(o_count), 0);
        step();
        step();
        RSTn = 1'b1;
        #1;
        chk("push7_ready", 32'(s_ready), 1);
        chk("push7_wrt", 32'(q_wrt), 1);
        chk("push7_data", 32'(q_data), 7);
        step();
        s_data = 16'd3;
        chk("settle1_wrt", 32'(q_wrt), 0);
        chk("settle1_qdata", 32'(q_data), 0);
        chk("settle1_ready", 32'(s_ready), 0);
        step();
        chk("settle2_wrt", 32'(q_wrt), 0);
        step();
        chk("push3_wrt", 32'(q_wrt), 1);
        chk("push3_data", 32'(q_data), 3);
        step();
        s_data = 16'd9;
        step();
        step();
        chk("push9_wrt", 32'(q_wrt), 1);
        chk("push9_data", 32'(q_data), 9);
        step();
        s_valid = 1'b0;
        step();
        step();
        chk("fill3_count", 32'(o_count), 3);
        chk("fill3_valid", 32'(m_valid), 1);
        chk("fill3_head", 32'(m_data), 3);
`ifdef PQ_STREAM_ADAPTER_STATS_EN
        chk("stat_push3", o_push_cnt, 3);
`endif
        m_ready = 1'b1;
        #1;
        chk("pop3_read", 32'(q_read), 1);
        chk("pop3_data", 32'(m_data), 3);
        step();
        chk("pop_gap1", 32'(m_valid), 0);
        step();
        chk("pop_gap2", 32'(m_valid), 0);
        step();
        chk("pop7_valid", 32'(m_valid), 1);
        chk("pop7_data", 32'(m_data), 7);
        step();
        step();
        step();
        chk("pop9_data", 32'(m_data), 9);
        chk("pop9_read", 32'(q_read), 1);
        step();
        step();
        step();
        chk("drained_valid", 32'(m_valid), 0);
        chk("drained_count", 32'(o_count), 0);
`ifdef PQ_STREAM_ADAPTER_STATS_EN
        chk("stat_pop3", o_pop_cnt, 3);
`endif
        m_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            s_valid = 1'b1;
            s_data  = 16'(10 * k);
            #1;
            chk("fill_wrt", 32'(q_wrt), 1);
            step();
            s_valid = 1'b0;
            step();
            step();
        end
        chk("full_count", 32'(o_count), 4);
        s_valid = 1'b1;
        s_data  = 16'd5;
        #1;
        chk("full_ready", 32'(s_ready), 0);
        chk("full_wrt", 32'(q_wrt), 0);
        chk("full_head", 32'(m_data), 10);
`ifdef PQ_STREAM_ADAPTER_STATS_EN
        stall0 = o_stall_cnt;
`endif
        step();
        step();
        chk("full_hold_wrt", 32'(q_wrt), 0);
        chk("full_hold_head", 32'(m_data), 10);
        chk("full_hold_count", 32'(o_count), 4);
`ifdef PQ_STREAM_ADAPTER_STATS_EN
        chk("stat_stall", o_stall_cnt, stall0 + 32'd2);
`endif
        m_ready = 1'b1;
        #1;
        chk("repl_wrt", 32'(q_wrt), 1);
        chk("repl_read", 32'(q_read), 1);
        chk("repl_data", 32'(q_data), 5);
        step();
        s_valid = 1'b0;
        m_ready = 1'b0;
        step();
        step();
        chk("repl_count", 32'(o_count), 4);
        chk("repl_head", 32'(m_data), 5);
        m_ready = 1'b1;
        #1;
        chk("pop5_read", 32'(q_read), 1);
        step();
        m_ready = 1'b0;
        step();
        step();
        chk("pop5_count", 32'(o_count), 3);
        chk("pop5_head", 32'(m_data), 20);
        s_valid = 1'b1;
        s_data  = 16'd8;
        #1;
        chk("push8_wrt", 32'(q_wrt), 1);
        step();
        s_valid = 1'b0;
        #2;
        RSTn = 1'b0;
        #1;
        chk("midrst_count", 32'(o_count), 0);
        chk("midrst_ready", 32'(s_ready), 0);
        chk("midrst_valid", 32'(m_valid), 0);
        chk("midrst_wrt", 32'(q_wrt), 0);
        chk("midrst_read", 32'(q_read), 0);
        chk("midrst_mdata", 32'(m_data), 0);
        step();
        RSTn = 1'b1;
        step();
        chk("post_rst_valid", 32'(m_valid), 0);
        chk("post_rst_count", 32'(o_count), 0);
        chk("post_rst_ready", 32'(s_ready), 1);
        s_valid = 1'b1;
        s_data  = 16'd1;
        #1;
        chk("post_rst_wrt", 32'(q_wrt), 1);
        step();
        s_valid = 1'b0;
        step();
        step();
        chk("post_rst_head", 32'(m_data), 1);
        chk("post_rst_cnt1", 32'(o_count), 1);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
